// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// funct3 codes, FSM state encoding and the store byte-enable decoder.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } dmem_state_t;

    function automatic logic [3:0] byte_en(
        input logic [2:0] funct3,
        input logic [1:0] off
    );
        logic [3:0] be;
        unique case (funct3)
            F3_B:    be = 4'b0001 << off;
            F3_H:    be = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/load_align.sv
// Little-endian load alignment: picks the byte/half/word out of a raw
// memory word and sign- or zero-extends it. Ports: word_i, off_i, funct3_i -> data_o.
module load_align
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (off_i)
            2'd0:    b = word_i[7:0];
            2'd1:    b = word_i[15:8];
            2'd2:    b = word_i[23:16];
            default: b = word_i[31:24];
        endcase
        h = off_i[1] ? word_i[31:16] : word_i[15:0];
        unique case (funct3_i)
            F3_B:    data_o = {{24{b[7]}}, b};
            F3_H:    data_o = {{16{h[15]}}, h};
            F3_W:    data_o = word_i;
            F3_BU:   data_o = {24'd0, b};
            F3_HU:   data_o = {16'd0, h};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised little-endian data SRAM with programmable latency behind a
// valid/ready request/response handshake. Ports: clk, rstn, req_* in, rsp_* out.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         IW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_t state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  f3_q;

    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH];

    logic        accept;
    logic        rsp_fire;
    logic        commit;

    logic        a_we;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic [2:0]  a_f3;
    logic [IW-1:0] a_idx;
    logic        f3_ok;
    logic        misal;
    logic        oor;
    logic        a_err;
    logic [3:0]  a_be;
    logic [31:0] wlanes;
    logic [31:0] rd_word;
    logic [31:0] ld_data;

    assign accept   = req_valid && req_ready;
    assign rsp_fire = rsp_valid && rsp_ready;

    // With single-cycle latency the access commits on the accepting edge,
    // so IDLE must use the live request instead of the capture registers.
    assign a_we    = (state_q == IDLE) ? req_we     : we_q;
    assign a_addr  = (state_q == IDLE) ? req_addr   : addr_q;
    assign a_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;
    assign a_f3    = (state_q == IDLE) ? req_funct3 : f3_q;

    assign a_idx   = a_addr[IW+1:2];
    assign a_be    = byte_en(a_f3, a_addr[1:0]);
    assign rd_word = mem_q[a_idx];

    always_comb begin
        unique case (a_f3)
            F3_B, F3_H, F3_W: f3_ok = 1'b1;
            F3_BU, F3_HU:     f3_ok = !a_we;
            default:          f3_ok = 1'b0;
        endcase
        misal = ((a_f3[1:0] == 2'b01) && a_addr[0])
             || ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));
        oor   = (a_addr >> (IW + 2)) != '0;
        a_err = !f3_ok || misal || oor;
    end

    // Store data is replicated across lanes; the byte enables pick the lanes.
    always_comb begin
        unique case (a_f3)
            F3_B:    wlanes = {4{a_wdata[7:0]}};
            F3_H:    wlanes = {2{a_wdata[15:0]}};
            default: wlanes = a_wdata;
        endcase
    end

    load_align u_align (
        .word_i   (rd_word),
        .off_i    (a_addr[1:0]),
        .funct3_i (a_f3),
        .data_o   (ld_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 1) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                if (rsp_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            IDLE:    req_ready = rstn;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
        commit = (state_d == RESP) && (state_q != RESP);
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            rdata_d = (a_we || a_err) ? 32'd0 : ld_data;
            err_d   = a_err;
        end else if (rsp_fire) begin
            rdata_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            f3_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
            end
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a reset in BUSY leaves commit low.
    always_ff @(posedge clk) begin
        if (commit && a_we && !a_err) begin
            for (int b = 0; b < 4; b++) begin
                if (a_be[b]) mem_q[a_idx][8*b +: 8] <= wlanes[8*b +: 8];
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder: two instances (latency 1 and 4)
// checked against a byte-level reference memory model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int L0 = 1;
    localparam int L1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rstn;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][2:0]  req_funct3;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] mdl [2][1024];

    dmem_responder #(.DEPTH(1024), .LATENCY(L0)) dut0 (
        .clk(clk), .rstn(rstn[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_funct3(req_funct3[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(1024), .LATENCY(L1)) dut1 (
        .clk(clk), .rstn(rstn[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_funct3(req_funct3[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    // Reference: byte-addressed view of the memory, sizes and signs
    // derived directly from the RISC-V load/store rules.
    function automatic void ref_access(
        input  int          d,
        input  bit          we,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [2:0]  f3,
        output logic [31:0] rd,
        output bit          er
    );
        int          sz;
        int          off;
        logic [31:0] w;
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default:    sz = 0;
        endcase
        if (we && f3[2]) sz = 0;
        er = (sz == 0);
        if (!er) er = (a % sz) != 0;
        if (!er) er = (a >= 32'd4096);
        rd = '0;
        if (!er) begin
            w   = mdl[d][a / 4];
            off = int'(a % 4);
            if (we) begin
                for (int i = 0; i < sz; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
                mdl[d][a / 4] = w;
            end else begin
                v = w >> (8 * off);
                if (sz == 1) begin
                    v = v & 32'hFF;
                    if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    v = v & 32'hFFFF;
                    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
                end
                rd = v;
            end
        end
    endfunction

    task automatic xact(
        input  int          d,
        input  bit          we,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        input  logic [2:0]  f3,
        input  int          hold,
        output logic [31:0] got_rd,
        output logic        got_er
    );
        logic [31:0] erd;
        bit          eer;
        int          lat;
        int          w;
        w = 0;
        while (!req_ready[d] && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        ref_access(d, we, a, wd, f3, erd, eer);
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        req_funct3[d] = f3;
        @(posedge clk);
        #1;
        // Request held valid with junk fields: must be ignored until IDLE.
        req_we[d]     = 1'($urandom);
        req_addr[d]   = $urandom;
        req_wdata[d]  = $urandom;
        req_funct3[d] = 3'($urandom);
        lat = 1;
        while (!rsp_valid[d] && lat < 40) begin
            chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_of(d)));
        got_rd = rsp_rdata[d];
        got_er = rsp_err[d];
        chk("rsp_rdata", rsp_rdata[d], erd);
        chk("rsp_err", 32'(rsp_err[d]), 32'(eer));
        chk("req_ready_resp", 32'(req_ready[d]), 32'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rdata", rsp_rdata[d], erd);
            chk("hold_err", 32'(rsp_err[d]), 32'(eer));
            chk("hold_ready", 32'(req_ready[d]), 32'd0);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        req_valid[d] = 1'b0;
        chk("clr_valid", 32'(rsp_valid[d]), 32'd0);
        chk("clr_rdata", rsp_rdata[d], 32'd0);
        chk("clr_err", 32'(rsp_err[d]), 32'd0);
        chk("idle_ready", 32'(req_ready[d]), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [31:0] v;
        logic [2:0]  f3s [5];
        logic [2:0]  f3;
        logic [31:0] a;
        int          d;
        bit          we;
        f3s = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};

        rstn       = '0;
        req_valid  = '0;
        req_we     = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_funct3 = '0;
        rsp_ready  = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
            chk("rst_rsp_rdata", rsp_rdata[i], 32'd0);
            chk("rst_rsp_err", 32'(rsp_err[i]), 32'd0);
        end
        rstn = 2'b11;
        @(posedge clk);
        #1;
        chk("rel_ready0", 32'(req_ready[0]), 32'd1);
        chk("rel_ready1", 32'(req_ready[1]), 32'd1);

        // Give every word used below a known value.
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 64; k++) begin
                xact(i, 1'b1, 32'(k * 4), $urandom, F3_W, 0, rd, er);
            end
            xact(i, 1'b1, 32'hFFC, $urandom, F3_W, 0, rd, er);
        end

        xact(0, 1'b1, 32'h10, 32'hDEAD_BEEF, F3_W, 0, rd, er);
        xact(0, 1'b0, 32'h10, 32'h0, F3_W, 0, rd, er);
        chk("tp_lw", rd, 32'hDEAD_BEEF);
        chk("tp_lw_err", 32'(er), 32'd0);

        xact(0, 1'b1, 32'h80, 32'h8000_00F0, F3_W, 0, rd, er);
        xact(0, 1'b0, 32'h80, 32'h0, F3_B, 0, rd, er);
        chk("tp_lb", rd, 32'hFFFF_FFF0);
        xact(0, 1'b0, 32'h80, 32'h0, F3_BU, 0, rd, er);
        chk("tp_lbu", rd, 32'h0000_00F0);
        xact(0, 1'b0, 32'h82, 32'h0, F3_H, 0, rd, er);
        chk("tp_lh", rd, 32'hFFFF_8000);
        xact(0, 1'b0, 32'h82, 32'h0, F3_HU, 0, rd, er);
        chk("tp_lhu", rd, 32'h0000_8000);

        xact(0, 1'b1, 32'h20, 32'h1111_1111, F3_W, 0, rd, er);
        xact(0, 1'b1, 32'h21, 32'h0000_00AA, F3_B, 0, rd, er);
        xact(0, 1'b0, 32'h20, 32'h0, F3_W, 0, rd, er);
        chk("tp_sb", rd, 32'h1111_AA11);

        xact(0, 1'b1, 32'h40, 32'h1234_5678, F3_W, 0, rd, er);
        xact(0, 1'b1, 32'h42, 32'hFFFF_FFFF, F3_W, 0, rd, er);
        chk("tp_misal_err", 32'(er), 32'd1);
        chk("tp_misal_rd", rd, 32'd0);
        xact(0, 1'b0, 32'h40, 32'h0, F3_W, 0, rd, er);
        chk("tp_misal_keep", rd, 32'h1234_5678);

        xact(0, 1'b0, 32'hFFC, 32'h0, F3_W, 0, rd, er);
        chk("last_word_ok", 32'(er), 32'd0);
        xact(0, 1'b0, 32'h1000, 32'h0, F3_W, 0, rd, er);
        chk("oor_err", 32'(er), 32'd1);
        xact(0, 1'b0, 32'h4, 32'h0, 3'b011, 0, rd, er);
        chk("bad_f3_err", 32'(er), 32'd1);
        xact(0, 1'b1, 32'h4, 32'h0, F3_BU, 0, rd, er);
        chk("st_bu_err", 32'(er), 32'd1);

        xact(1, 1'b1, 32'h30, 32'hCAFE_F00D, F3_W, 0, rd, er);
        xact(1, 1'b0, 32'h30, 32'h0, F3_W, 3, rd, er);
        chk("tp_hold_data", rd, 32'hCAFE_F00D);

        // Reset while a store is pending must abort it.
        xact(1, 1'b1, 32'h0, 32'h0, F3_W, 0, rd, er);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_addr[1]   = 32'h0;
        req_wdata[1]  = 32'h5;
        req_funct3[1] = F3_W;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rstn[1] = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready[1]), 32'd0);
        chk("abort_valid", 32'(rsp_valid[1]), 32'd0);
        chk("abort_rdata", rsp_rdata[1], 32'd0);
        chk("abort_err", 32'(rsp_err[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_valid2", 32'(rsp_valid[1]), 32'd0);
        rstn[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_rel_ready", 32'(req_ready[1]), 32'd1);
        xact(1, 1'b0, 32'h0, 32'h0, F3_W, 0, rd, er);
        chk("abort_no_store", rd, 32'h0);

        for (int i = 0; i < 200; i++) begin
            d  = $urandom_range(0, 1);
            we = 1'($urandom);
            if ($urandom_range(0, 9) < 8) f3 = f3s[$urandom_range(0, 4)];
            else f3 = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom | 32'h1000;
            end else begin
                a = 32'($urandom_range(0, 255));
                if ($urandom_range(0, 3) != 0) begin
                    if (f3[1:0] == 2'b01) a[0] = 1'b0;
                    if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
                end
            end
            v = $urandom;
            xact(d, we, a, v, f3, $urandom_range(0, 2), rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
